// File: rtl/nack_skid_slice_pkg.sv
// Shared token types and FSM encoding for the Nack skid slice.
// The optional overflow checker is enabled by defining NACK_SKID_OVF_CHK_EN.
package nack_skid_slice_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic v;
    logic t;
    logic c;
    logic n;
  } BTk_t;

  typedef enum logic [1:0] {
    PASS  = 2'h0,
    HOLD  = 2'h1,
    DRAIN = 2'h2
  } skid_fsm_t;

endpackage

// File: rtl/nack_skid_slice_skid_ring.sv
// DEPTH-entry ring store with push/pop/occupancy; push and pop together on a
// full store is legal (the popped head is the old head).
module skid_ring #(
  parameter int  DEPTH = 3,
  parameter type T     = logic [7:0],
  parameter int  OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  T                 din,
  output T                 head,
  output logic [OCC_W-1:0] occ,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    wrap_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full    = (occ == OCC_W'(DEPTH));
    do_pop  = pop && (occ != '0);
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nack_skid_slice.sv
// Registered output slice that absorbs the upstream's in-flight tokens after Nack.
// Define NACK_SKID_OVF_CHK_EN for the sticky overflow flag and drop assertion.
module nack_skid_slice
  import nack_skid_slice_pkg::*;
#(
  parameter int  SKID_DEPTH = 3,
  parameter type TYPE_FWRD  = FTk_t
) (
  input  logic                        clock,
  input  logic                        reset,
  input  TYPE_FWRD                    I_FTk,
  output BTk_t                        O_BTk,
  output TYPE_FWRD                    O_FTk,
  input  BTk_t                        I_BTk,
  output logic [$clog2(SKID_DEPTH):0] O_Occ,
  output logic                        O_Ovf
);

  localparam int OCC_W = $clog2(SKID_DEPTH) + 1;

  skid_fsm_t        state;
  TYPE_FWRD         out_p1;
  TYPE_FWRD         head;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             full;
  logic             stall;
  logic             has_skid;
  logic             push_req;
  logic             push;
  logic             pop;

  function automatic TYPE_FWRD clean_tok(input TYPE_FWRD t);
    clean_tok = t.v ? t : '0;
  endfunction

  // Whenever the skid holds anything, new tokens queue behind it so order is kept.
  always_comb begin
    stall    = I_BTk.n;
    has_skid = (occ != '0);
    pop      = !stall && has_skid;
    push_req = I_FTk.v && ((stall && (state != PASS)) || pop);
    push     = push_req && (!full || pop);
    occ_next = occ + OCC_W'(push) - OCC_W'(pop);
  end

  skid_ring #(
    .DEPTH (SKID_DEPTH),
    .T     (TYPE_FWRD),
    .OCC_W (OCC_W)
  ) u_ring (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (I_FTk),
    .head  (head),
    .occ   (occ),
    .full  (full)
  );

  // ---- stage p1: output register and FSM ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= PASS;
      out_p1 <= '0;
    end else begin
      unique case (state)
        PASS: begin
          out_p1 <= clean_tok(I_FTk);
          state  <= stall ? HOLD : PASS;
        end
        HOLD, DRAIN: begin
          if (stall) begin
            state <= HOLD;
          end else if (has_skid) begin
            out_p1 <= head;
            state  <= (occ_next != '0) ? DRAIN : PASS;
          end else begin
            out_p1 <= clean_tok(I_FTk);
            state  <= PASS;
          end
        end
        default: begin
          state  <= PASS;
          out_p1 <= '0;
        end
      endcase
    end
  end

  // Nack goes upstream combinationally; the skid keeps it high until empty.
  always_comb begin
    O_BTk   = I_BTk;
    O_BTk.n = I_BTk.n | has_skid;
    O_FTk   = out_p1;
    O_Occ   = occ;
  end

`ifdef NACK_SKID_OVF_CHK_EN
  logic drop;
  logic ovf;

  assign drop  = push_req && full && !pop;
  assign O_Ovf = ovf;

  always_ff @(posedge clock) begin
    if (reset)     ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

  a_no_drop: assert property (@(posedge clock) disable iff (reset) !drop)
    else $error("nack_skid_slice: skid full, token dropped");
`else
  assign O_Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nack_skid_slice.sv
// Directed and randomized bench for nack_skid_slice against a queue-based model.
module tb_nack_skid_slice;
  import nack_skid_slice_pkg::*;

  localparam int DEPTH = 3;

  logic       clock;
  logic       reset;
  FTk_t       I_FTk;
  BTk_t       O_BTk;
  FTk_t       O_FTk;
  BTk_t       I_BTk;
  logic [2:0] O_Occ;
  logic       O_Ovf;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  FTk_t m_out  = '0;
  FTk_t m_q[$];
  bit   m_pass = 1;
  bit   m_ovf  = 0;

  nack_skid_slice #(.SKID_DEPTH(DEPTH), .TYPE_FWRD(FTk_t)) dut (
    .clock (clock),
    .reset (reset),
    .I_FTk (I_FTk),
    .O_BTk (O_BTk),
    .O_FTk (O_FTk),
    .I_BTk (I_BTk),
    .O_Occ (O_Occ),
    .O_Ovf (O_Ovf)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic FTk_t clean(input FTk_t t);
    return t.v ? t : '0;
  endfunction

  // Reference: the output register plus an ordered queue of waiting tokens.
  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_out  = '0;
      m_pass = 1;
      m_ovf  = 0;
    end else if (I_BTk.n) begin
      if (m_pass) m_out = clean(I_FTk);
      else if (I_FTk.v) begin
        if (m_q.size() < DEPTH) m_q.push_back(I_FTk);
        else m_ovf = 1;
      end
      m_pass = 0;
    end else if (m_q.size() > 0) begin
      m_out = m_q.pop_front();
      if (I_FTk.v) m_q.push_back(I_FTk);
      m_pass = (m_q.size() == 0);
    end else begin
      m_out  = clean(I_FTk);
      m_pass = 1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("ftk", {23'd0, O_FTk}, {23'd0, m_out});
      check("occ", {29'd0, O_Occ}, 32'(m_q.size()));
      check("btk_n", {31'd0, O_BTk.n}, {31'd0, I_BTk.n | (m_q.size() != 0)});
      check("btk_pass", {29'd0, O_BTk.v, O_BTk.t, O_BTk.c}, {29'd0, I_BTk.v, I_BTk.t, I_BTk.c});
`ifdef NACK_SKID_OVF_CHK_EN
      check("ovf", {31'd0, O_Ovf}, {31'd0, m_ovf});
`else
      check("ovf", {31'd0, O_Ovf}, 32'd0);
`endif
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit n);
    I_FTk.v = v;
    I_FTk.d = d;
    I_BTk.n = n;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string nm, input bit v, input logic [7:0] d, input int occ);
    check({nm, "_v"}, {31'd0, O_FTk.v}, {31'd0, v});
    check({nm, "_d"}, {24'd0, O_FTk.d}, {24'd0, d});
    check({nm, "_occ"}, {29'd0, O_Occ}, 32'(occ));
  endtask

  initial begin
    reset = 1;
    I_FTk = '0;
    I_BTk = '0;
    repeat (2) @(posedge clock);
    #1;
    expect_out("rst", 0, 8'd0, 0);
    check("rst_ovf", {31'd0, O_Ovf}, 32'd0);
    check("rst_btk_n", {31'd0, O_BTk.n}, 32'd0);
    reset  = 0;
    chk_en = 1;

    // Streaming without Nack
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 0);
      expect_out("stream", 1, 8'(i), 0);
      check("stream_btk_n", {31'd0, O_BTk.n}, 32'd0);
    end
    cyc(0, 8'd0, 0);
    expect_out("stream_idle", 0, 8'd0, 0);

    // Nack for 4 cycles, two tokens land in the skid
    cyc(1, 8'd3, 0);
    cyc(1, 8'd4, 1);
    expect_out("hold_load", 1, 8'd4, 0);
    cyc(1, 8'd5, 1);
    cyc(1, 8'd6, 1);
    cyc(0, 8'd0, 1);
    expect_out("hold", 1, 8'd4, 2);
    check("mdl_occ", 32'(m_q.size()), 32'd2);
    check("hold_btk_n", {31'd0, O_BTk.n}, 32'd1);
    cyc(0, 8'd0, 0);
    expect_out("drain5", 1, 8'd5, 1);
    check("drain_btk_n", {31'd0, O_BTk.n}, 32'd1);
    cyc(0, 8'd0, 0);
    expect_out("drain6", 1, 8'd6, 0);
    check("empty_btk_n", {31'd0, O_BTk.n}, 32'd0);
    cyc(0, 8'd0, 0);
    expect_out("pass_idle", 0, 8'd0, 0);

    // Nack during DRAIN with two entries waiting
    cyc(1, 8'd10, 1);
    cyc(1, 8'd11, 1);
    cyc(1, 8'd12, 1);
    cyc(1, 8'd13, 1);
    expect_out("fill3", 1, 8'd10, 3);
    cyc(0, 8'd0, 0);
    expect_out("drain11", 1, 8'd11, 2);
    cyc(0, 8'd0, 1);
    expect_out("rehold", 1, 8'd11, 2);
    cyc(0, 8'd0, 0);
    expect_out("drain12", 1, 8'd12, 1);
    cyc(0, 8'd0, 0);
    expect_out("drain13", 1, 8'd13, 0);

    // Enqueue and dequeue in the same DRAIN cycle
    cyc(1, 8'd6, 1);
    cyc(1, 8'd7, 1);
    expect_out("one_in_skid", 1, 8'd6, 1);
    cyc(1, 8'd8, 0);
    expect_out("swap7", 1, 8'd7, 1);
    cyc(0, 8'd0, 0);
    expect_out("swap8", 1, 8'd8, 0);

    // Overflow: fourth token during HOLD is dropped
    cyc(1, 8'd20, 1);
    for (int i = 21; i <= 24; i++) cyc(1, 8'(i), 1);
    expect_out("full", 1, 8'd20, 3);
`ifdef NACK_SKID_OVF_CHK_EN
    check("ovf_set", {31'd0, O_Ovf}, 32'd1);
`else
    check("ovf_off", {31'd0, O_Ovf}, 32'd0);
`endif
    cyc(0, 8'd0, 0);
    expect_out("ovf21", 1, 8'd21, 2);
    cyc(0, 8'd0, 0);
    cyc(0, 8'd0, 0);
    expect_out("ovf23", 1, 8'd23, 0);
    cyc(0, 8'd0, 0);
    expect_out("ovf_no24", 0, 8'd0, 0);

    // Reset in the middle of DRAIN
    cyc(1, 8'd30, 1);
    for (int i = 31; i <= 33; i++) cyc(1, 8'(i), 1);
    cyc(0, 8'd0, 0);
    expect_out("pre_rst", 1, 8'd31, 2);
    reset = 1;
    cyc(0, 8'd0, 1);
    reset = 0;
    expect_out("mid_rst", 0, 8'd0, 0);
    check("mid_rst_btk_n", {31'd0, O_BTk.n}, 32'd1);
    cyc(1, 8'd40, 0);
    expect_out("post_rst", 1, 8'd40, 0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 2000; i++) begin
      I_BTk.v = 1'($urandom);
      I_BTk.t = 1'($urandom);
      I_BTk.c = 1'($urandom);
      if (i == 1000) reset = 1;
      else reset = 0;
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 4);
    end
    reset = 0;
    for (int i = 0; i < 6; i++) cyc(0, 8'd0, 0);
    expect_out("final_idle", 0, 8'd0, 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
